// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU arbiter and the ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, ready may depend on valid.
interface alu_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_opcode;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_result;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_opcode;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_result;

   // Requester side
   modport master (
      output req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_result,
      input  req1_ready, rsp1_valid, rsp1_result
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_result,
      output req1_ready, rsp1_valid, rsp1_result
   );
endinterface

// File: rtl/alu.sv
// Combinational 8-operation ALU; ADD/SUB wrap modulo 2^WIDTH, shifts zero-fill.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic [WIDTH-1:0] result
);

   // Operation select
   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = operandA + operandB;
         OP_SUB:  result = operandA - operandB;
         OP_AND:  result = operandA & operandB;
         OP_OR:   result = operandA | operandB;
         OP_XOR:  result = operandA ^ operandB;
         OP_NOT:  result = ~operandA;
         OP_SHL:  result = {operandA[WIDTH-2:0], 1'b0};
         OP_SHR:  result = {1'b0, operandA[WIDTH-1:1]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one operation in flight at a time.
// Ties are broken round-robin; the FSM walks IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output state_t           state
);

   state_t           state_q, state_d;
   logic             owner_q;
   logic             last_grant_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] res0_q, res1_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] alu_out;

   logic grant;
   logic ready0, ready1;
   logic accept;
   logic rsp_hs;

   // Arbitration: a lone valid port wins; on a tie the port not served last wins
   always_comb begin
      grant  = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
      ready0 = rst_n & (state_q == ST_IDLE) & bus.req0_valid & ~grant;
      ready1 = rst_n & (state_q == ST_IDLE) & bus.req1_valid & grant;
      accept = ready0 | ready1;
      rsp_hs = (state_q == ST_RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_hs) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Operand capture, result capture and completion counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res0_q       <= '0;
         res1_q       <= '0;
         count_q      <= '0;
      end else begin
         if (accept) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            op_q         <= grant ? bus.req1_opcode : bus.req0_opcode;
            a_q          <= grant ? bus.req1_a      : bus.req0_a;
            b_q          <= grant ? bus.req1_b      : bus.req0_b;
         end
         if (state_q == ST_EXEC) begin
            if (owner_q) res1_q <= alu_out;
            else         res0_q <= alu_out;
         end
         if (rsp_hs) count_q <= count_q + 1'b1;
      end
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .opcode   (op_q),
      .operandA (a_q),
      .operandB (b_q),
      .result   (alu_out)
   );

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.rsp0_valid  = (state_q == ST_RESP) & ~owner_q;
   assign bus.rsp1_valid  = (state_q == ST_RESP) & owner_q;
   assign bus.rsp0_result = res0_q;
   assign bus.rsp1_result = res1_q;
   assign busy            = rst_n & (state_q != ST_IDLE);
   assign op_count        = count_q;
   assign state           = state_q;

endmodule
